// File: rtl/sync_pkg.sv
// ============================================================================
// Module : sync_pkg
// Brief  : Shared constants, types and helpers for the multi-channel
//          synchronizer (optional glitch filter: SYNC_FILTER_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    // Counter must hold 0..FILTER_LEN-1; sized generously as clog2(FILTER_LEN+1).
    function automatic int sync_cnt_width(input int filter_len);
        return (filter_len < 1) ? 1 : $clog2(filter_len + 1);
    endfunction

    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } sync_ch_t;

endpackage

`default_nettype wire

// File: rtl/sync_ch_edge.sv
// ============================================================================
// Module : sync_ch_edge
// Brief  : One channel: flop-chain synchronizer, optional glitch filter
//          (SYNC_FILTER_EN) and registered rise/fall strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_ch_edge
    import sync_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter logic RST_VAL    = 1'b0,
    parameter int   FILTER_LEN = 3
) (
    input  logic     clk,
    input  logic     n_rst,
    input  logic     i_async,
    output sync_ch_t o_ch,
    output logic     o_edge_nxt
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_ch_edge: STAGES must be >= %0d", SYNC_MIN_STAGES);
    end

    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("sync_ch_edge: FILTER_LEN must be >= 1");
    end

    logic [STAGES-1:0] r_stage;
    logic              w_cand;
    logic              w_lvl;
    logic              w_rise_nxt;
    logic              w_fall_nxt;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stage <= {STAGES{RST_VAL}};
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_async};
        end
    end

    assign w_cand = r_stage[STAGES-1];

`ifdef SYNC_FILTER_EN
    localparam int              CNT_W      = sync_cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_flt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_commit;

    assign w_commit = (w_cand != r_flt) && (r_cnt == C_CNT_LAST);

    // Any return to the filtered level restarts the stability count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_flt <= RST_VAL;
            r_cnt <= '0;
        end else if (w_cand == r_flt) begin
            r_cnt <= '0;
        end else if (w_commit) begin
            r_flt <= w_cand;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_lvl      = r_flt;
    assign w_rise_nxt = w_commit &  w_cand;
    assign w_fall_nxt = w_commit & ~w_cand;
`else
    // Look one stage ahead so the registered strobe lands with the level change.
    assign w_lvl      = w_cand;
    assign w_rise_nxt =  r_stage[STAGES-2] & ~w_cand;
    assign w_fall_nxt = ~r_stage[STAGES-2] &  w_cand;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    assign o_ch.lvl   = w_lvl;
    assign o_ch.rise  = r_rise;
    assign o_ch.fall  = r_fall;
    assign o_edge_nxt = w_rise_nxt | w_fall_nxt;

endmodule

`default_nettype wire

// File: rtl/sync_multi_edge.sv
// ============================================================================
// Module : sync_multi_edge
// Brief  : WIDTH independent synchronizer channels with rise/fall strobes and
//          a registered any-edge flag (optional glitch filter: SYNC_FILTER_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_multi_edge
    import sync_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter int   STAGES     = 2,
    parameter logic RST_VAL    = 1'b0,
    parameter int   FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_multi_edge: WIDTH must be >= 1");
    end

    sync_ch_t         w_ch [WIDTH];
    logic [WIDTH-1:0] w_edge_nxt;
    logic             r_any;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        sync_ch_edge #(
            .STAGES     (STAGES),
            .RST_VAL    (RST_VAL),
            .FILTER_LEN (FILTER_LEN)
        ) u_ch (
            .clk        (clk),
            .n_rst      (n_rst),
            .i_async    (async_in[gi]),
            .o_ch       (w_ch[gi]),
            .o_edge_nxt (w_edge_nxt[gi])
        );

        assign sync_out[gi] = w_ch[gi].lvl;
        assign rise[gi]     = w_ch[gi].rise;
        assign fall[gi]     = w_ch[gi].fall;
    end

    // Built from the channels' next-strobe terms so it lines up with rise/fall.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_edge_nxt;
        end
    end

    assign any_edge = r_any;

endmodule

`default_nettype wire

// File: tb/tb_sync_multi_edge.sv
// ============================================================================
// Module : tb_sync_multi_edge
// Brief  : Scoreboard bench for sync_multi_edge (honours SYNC_FILTER_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sync_multi_edge;

`ifdef SYNC_FILTER_EN
    localparam int FLT = 3;
`else
    localparam int FLT = 0;
`endif
    localparam int LA = 2 + FLT;
    localparam int LB = 4 + FLT;

    typedef struct {
        int         cyc;
        int         tag;
        logic [3:0] so;
        logic [3:0] ri;
        logic [3:0] fa;
        logic       an;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] async_a, async_b;
    logic [3:0] so_a, ri_a, fa_a, so_b, ri_b, fa_b;
    logic       an_a, an_b;

    int   cyc_cnt = 0;
    int   tests   = 0;
    int   failed  = 0;
    exp_t qa[$];
    exp_t qb[$];
    event mon_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    sync_multi_edge #(.WIDTH(4), .STAGES(2), .RST_VAL(1'b0), .FILTER_LEN(3)) dut_a (
        .clk(clk), .n_rst(n_rst), .async_in(async_a),
        .sync_out(so_a), .rise(ri_a), .fall(fa_a), .any_edge(an_a)
    );

    sync_multi_edge #(.WIDTH(4), .STAGES(4), .RST_VAL(1'b1), .FILTER_LEN(3)) dut_b (
        .clk(clk), .n_rst(n_rst), .async_in(async_b),
        .sync_out(so_b), .rise(ri_b), .fall(fa_b), .any_edge(an_b)
    );

    task automatic push(input int sel, input exp_t e);
        if (sel == 0) qa.push_back(e);
        else          qb.push_back(e);
    endtask

    task automatic push_imm(input int sel, input int tag, input logic [3:0] so);
        exp_t e;
        e.cyc = -1; e.tag = tag; e.so = so; e.ri = 4'h0; e.fa = 4'h0; e.an = 1'b0;
        push(sel, e);
    endtask

    // Expected response to a step old->new: level flips and strobes fire on edge lat.
    task automatic push_step(input int sel, input int tag, input logic [3:0] oldv,
                             input logic [3:0] newv, input int lat);
        exp_t e;
        for (int k = 1; k <= lat + 1; k++) begin
            e.cyc = cyc_cnt + k;
            e.tag = tag;
            e.so  = (k < lat) ? oldv : newv;
            e.ri  = (k == lat) ? (newv & ~oldv) : 4'h0;
            e.fa  = (k == lat) ? (oldv & ~newv) : 4'h0;
            e.an  = (k == lat) && (oldv != newv);
            push(sel, e);
        end
    endtask

    task automatic run_a(input int tag, input logic [3:0] newv, input logic [3:0] oldv);
        async_a = newv;
        push_step(0, tag, oldv, newv, LA);
        repeat (LA + 1) @(negedge clk);
    endtask

    task automatic run_b(input int tag, input logic [3:0] newv, input logic [3:0] oldv);
        async_b = newv;
        push_step(1, tag, oldv, newv, LB);
        repeat (LB + 1) @(negedge clk);
    endtask

    function automatic logic tog_seq(input int m);
        return (m >= 1 && m <= 10) ? m[0] : 1'b0;
    endfunction

    task automatic compare(input int sel, input exp_t e);
        logic [3:0] so, ri, fa;
        logic       an;
        if (sel == 0) begin so = so_a; ri = ri_a; fa = fa_a; an = an_a; end
        else          begin so = so_b; ri = ri_b; fa = fa_b; an = an_b; end
        tests++;
        if ({so, ri, fa, an} !== {e.so, e.ri, e.fa, e.an}) begin
            failed++;
            $display("FAIL chk%0d dut%0d cyc%0d: got out=%h rise=%h fall=%h any=%b, want out=%h rise=%h fall=%h any=%b",
                     e.tag, sel, cyc_cnt, so, ri, fa, an, e.so, e.ri, e.fa, e.an);
        end
        tests++;
        if ((ri & fa) != 4'h0) begin
            failed++;
            $display("FAIL both_strobes dut%0d cyc%0d: got rise=%h fall=%h, want disjoint",
                     sel, cyc_cnt, ri, fa);
        end
    endtask

    task automatic service(input int sel);
        exp_t e;
        bit   have;
        forever begin
            have = 1'b0;
            if (sel == 0 && qa.size() > 0 && qa[0].cyc <= cyc_cnt) begin
                e = qa.pop_front(); have = 1'b1;
            end else if (sel == 1 && qb.size() > 0 && qb[0].cyc <= cyc_cnt) begin
                e = qb.pop_front(); have = 1'b1;
            end
            if (!have) break;
            if (e.cyc >= 0 && e.cyc < cyc_cnt) begin
                tests++;
                failed++;
                $display("FAIL missed_sample chk%0d dut%0d: got cyc%0d, want cyc%0d",
                         e.tag, sel, cyc_cnt, e.cyc);
            end else begin
                compare(sel, e);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or mon_ev);
            #1;
            service(0);
            service(1);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        exp_t e;
        logic cur, prv;

        n_rst   = 1'b0;
        async_a = 4'hF;
        async_b = 4'hF;

        // 1: reset values, then release with inputs away from RST_VAL on A
        @(negedge clk);
        push_imm(0, 1, 4'h0);
        push_imm(1, 1, 4'hF);
        -> mon_ev;
        #2;
        @(negedge clk);
        n_rst = 1'b1;
        push_step(0, 1, 4'h0, 4'hF, LA);
        push_step(1, 1, 4'hF, 4'hF, LB);
        repeat (LB + 1) @(negedge clk);

        // 2: level steps on A
        run_a(2, 4'h0, 4'hF);
        run_a(2, 4'h5, 4'h0);
        run_a(2, 4'h0, 4'h5);

        // 3: deeper chain, idle-high reset, drop bit 2
        run_b(3, 4'hB, 4'hF);

        // 4: toggle bit 0 every cycle
        base = cyc_cnt;
        for (int n = 1; n <= 10 + LA; n++) begin
`ifdef SYNC_FILTER_EN
            cur = 1'b0;
            prv = 1'b0;
`else
            cur = tog_seq(n - LA + 1);
            prv = tog_seq(n - LA);
`endif
            e.cyc = base + n; e.tag = 4;
            e.so = {3'b000, cur};
            e.ri = {3'b000, cur & ~prv};
            e.fa = {3'b000, ~cur & prv};
            e.an = cur ^ prv;
            qa.push_back(e);
        end
        for (int j = 1; j <= 10; j++) begin
            async_a = {3'b000, j[0]};
            @(negedge clk);
        end
        async_a = 4'h0;
        repeat (LA) @(negedge clk);

        // 5: reset one cycle into a transition
        async_a = 4'hF;
        e.cyc = cyc_cnt + 1; e.tag = 5;
        e.so = 4'h0; e.ri = 4'h0; e.fa = 4'h0; e.an = 1'b0;
        qa.push_back(e);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        push_imm(0, 5, 4'h0);
        push_imm(1, 5, 4'hF);
        -> mon_ev;
        async_a = 4'h0;
        #2;
        @(negedge clk);
        n_rst = 1'b1;
        push_step(0, 5, 4'h0, 4'h0, LA);
        push_step(1, 5, 4'hF, 4'hB, LB);
        repeat (LB + 1) @(negedge clk);

`ifdef SYNC_FILTER_EN
        // 6: short glitch is swallowed, a stable level commits
        base = cyc_cnt;
        for (int n = 1; n <= LA + 3; n++) begin
            e.cyc = base + n; e.tag = 6;
            e.so = 4'h0; e.ri = 4'h0; e.fa = 4'h0; e.an = 1'b0;
            qa.push_back(e);
        end
        async_a = 4'h2;
        repeat (2) @(negedge clk);
        async_a = 4'h0;
        repeat (LA + 1) @(negedge clk);
        run_a(6, 4'h2, 4'h0);
`endif

        repeat (2) @(negedge clk);
        tests++;
        if (qa.size() + qb.size() != 0) begin
            failed++;
            $display("FAIL leftover_expect: got %0d pending, want 0", qa.size() + qb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
